// File: rtl/nbit_sub_pkg.sv
// Shared definitions for the N-bit subtractor core.
//   FLAG_N/C/Z/V : bit positions of the status flags inside flags_t
//   flags_t      : packed 4-bit status vector {n, c, z, v}
//   DEFAULT_LEN  : default operand/result width
package nbit_sub_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned DEFAULT_LEN = 4;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/nbit_subtractor_core_if.sv
// Operand/result bundle for the N-bit subtractor core.
//   a, b      : minuend and subtrahend (driven by the master)
//   bin       : borrow-in, present only when NBIT_SUB_BORROW_IN_EN is defined
//   response  : registered difference (driven by the slave)
//   n, c, z, v: registered status flags (driven by the slave)
// Modports: master = operand source / result sink, slave = subtractor core.
interface nbit_subtractor_core_if
    import nbit_sub_pkg::*;
#(
    parameter int unsigned len = DEFAULT_LEN
);

    logic [len-1:0] a;
    logic [len-1:0] b;
`ifdef NBIT_SUB_BORROW_IN_EN
    logic           bin;
`endif
    logic [len-1:0] response;
    logic           n;
    logic           c;
    logic           z;
    logic           v;

`ifdef NBIT_SUB_BORROW_IN_EN
    modport master (output a, b, bin, input response, n, c, z, v);
    modport slave  (input a, b, bin, output response, n, c, z, v);
`else
    modport master (output a, b, input response, n, c, z, v);
    modport slave  (input a, b, output response, n, c, z, v);
`endif

endinterface

// File: rtl/nbit_sub_comb.sv
// Purely combinational N-bit subtract with NZCV flags.
//   i_a, i_b : operands
//   i_bin    : borrow-in (only when NBIT_SUB_BORROW_IN_EN is defined)
//   o_diff   : (i_a - i_b - borrow) mod 2^len
//   o_flags  : {n, c, z, v}; c uses the no-borrow convention
module nbit_sub_comb
    import nbit_sub_pkg::*;
#(
    parameter int unsigned len = DEFAULT_LEN
) (
    input  logic [len-1:0] i_a,
    input  logic [len-1:0] i_b,
`ifdef NBIT_SUB_BORROW_IN_EN
    input  logic           i_bin,
`endif
    output logic [len-1:0] o_diff,
    output flags_t         o_flags
);

    logic           w_cin;
    logic [len:0]   w_sum;
    logic [len-1:0] w_diff;

    // Subtract as a + ~b + carry-in; carry-in is the inverted borrow.
`ifdef NBIT_SUB_BORROW_IN_EN
    assign w_cin = ~i_bin;
`else
    assign w_cin = 1'b1;
`endif

    assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{len{1'b0}}, w_cin};
    assign w_diff = w_sum[len-1:0];
    assign o_diff = w_diff;

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = w_diff[len-1];
        o_flags[FLAG_C] = w_sum[len];
        o_flags[FLAG_Z] = (w_diff == '0);
        // Overflow only possible when operand signs differ and the result
        // sign does not follow the minuend.
        o_flags[FLAG_V] = (i_a[len-1] != i_b[len-1]) && (w_diff[len-1] != i_a[len-1]);
    end

endmodule

// File: rtl/nbit_subtractor_core.sv
// N-bit two's-complement subtractor with registered difference and NZCV flags.
// One-cycle latency, one result per cycle, no handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears response and all flags
//   bus   : nbit_subtractor_core_if.slave (a, b[, bin] in; response, n, c, z, v out)
// Optional feature: define NBIT_SUB_BORROW_IN_EN to add the bin borrow-in input.
module nbit_subtractor_core
    import nbit_sub_pkg::*;
#(
    parameter int unsigned len = DEFAULT_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nbit_subtractor_core_if.slave        bus
);

    logic [len-1:0] w_diff;
    flags_t         w_flags;
    logic [len-1:0] r_response;
    flags_t         r_flags;

    nbit_sub_comb #(
        .len (len)
    ) u_comb (
        .i_a     (bus.a),
        .i_b     (bus.b),
`ifdef NBIT_SUB_BORROW_IN_EN
        .i_bin   (bus.bin),
`endif
        .o_diff  (w_diff),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_response <= '0;
            r_flags    <= '0;
        end else begin
            r_response <= w_diff;
            r_flags    <= w_flags;
        end
    end

    assign bus.response = r_response;
    assign bus.n        = r_flags[FLAG_N];
    assign bus.c        = r_flags[FLAG_C];
    assign bus.z        = r_flags[FLAG_Z];
    assign bus.v        = r_flags[FLAG_V];

endmodule

// File: tb/tb_nbit_subtractor_core.sv
// Self-checking bench for nbit_subtractor_core: directed vectors, reset
// behaviour and randomized operands against an arithmetic reference model.
module tb_nbit_subtractor_core;

    localparam int LEN = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    nbit_subtractor_core_if #(.len(LEN)) u_if ();

    nbit_subtractor_core #(
        .len (LEN)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    // Returns {response, n, c, z, v}.
    function automatic logic [LEN+3:0] model(input int a, input int b, input int bin);
        int          modv;
        int          d;
        int          sa;
        int          sb;
        int          sd;
        logic [LEN-1:0] r;
        logic        n, c, z, v;
        modv = 1 << LEN;
        d    = a - b - bin;
        if (d < 0) d = d + modv;
        r    = d[LEN-1:0];
        sa   = (a >= modv / 2) ? a - modv : a;
        sb   = (b >= modv / 2) ? b - modv : b;
        sd   = sa - sb - bin;
        n    = (d >= modv / 2);
        c    = (a >= b + bin);
        z    = (d == 0);
        v    = (sd < -(modv / 2)) || (sd > (modv / 2) - 1);
        return {r, n, c, z, v};
    endfunction

    function automatic logic [LEN+3:0] observed();
        return {u_if.response, u_if.n, u_if.c, u_if.z, u_if.v};
    endfunction

    task automatic check(input string tag, input logic [LEN+3:0] obs,
                         input logic [LEN+3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed resp/nczv=%b/%b required %b/%b", tag,
                   obs[LEN+3:4], obs[3:0], exp[LEN+3:4], exp[3:0]);
        end
    endtask

    task automatic drive(input int a, input int b, input int bin);
        u_if.a = a[LEN-1:0];
        u_if.b = b[LEN-1:0];
`ifdef NBIT_SUB_BORROW_IN_EN
        u_if.bin = bin[0];
`endif
    endtask

    // Wait one edge and compare against the model for the currently driven operands.
    task automatic step_check(input string tag, input int a, input int b, input int bin);
        @(posedge clk);
        #1;
        check(tag, observed(), model(a, b, bin));
    endtask

    task automatic apply(input string tag, input int a, input int b, input int bin);
        drive(a, b, bin);
        step_check(tag, a, b, bin);
    endtask

    int ra, rb, rbin;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(7, 2, 0);

        // Reset clears outputs without any clock edge.
        #2;
        check("reset_no_edge", observed(), '0);
        @(posedge clk);
        #1;
        check("reset_held", observed(), '0);

        // First edge after release samples operands immediately.
        rst_n = 1'b1;
        step_check("first_after_reset", 7, 2, 0);
        check("first_after_reset_const", observed(), {4'b0101, 4'b0100});

        apply("a2_b3", 2, 3, 0);
        check("a2_b3_const", observed(), {4'b1111, 4'b1000});
        apply("a2_b1", 2, 1, 0);
        apply("a14_b1", 14, 1, 0);
        apply("ovf_neg_minus1", 8, 1, 0);
        check("ovf_neg_minus1_const", observed(), {4'b0111, 4'b0101});
        apply("ovf_zero_minus_neg", 0, 8, 0);
        check("ovf_zero_minus_neg_const", observed(), {4'b1000, 4'b1001});
        apply("zero_eq", 5, 5, 0);
        check("zero_eq_const", observed(), {4'b0000, 4'b0110});
        apply("zero_zero", 0, 0, 0);
        apply("max_minus_zero", 15, 0, 0);
        apply("zero_minus_max", 0, 15, 0);
        apply("pos_max_minus_neg", 7, 15, 0);
        apply("pos_max_minus_mneg", 7, 8, 0);
`ifdef NBIT_SUB_BORROW_IN_EN
        apply("bin_zero", 5, 4, 1);
        check("bin_zero_const", observed(), {4'b0000, 4'b0110});
        apply("bin_borrow", 0, 0, 1);
        apply("bin_ovf", 8, 0, 1);
`endif

        // Asynchronous reset mid-stream discards the pending operation.
        apply("pre_reset", 3, 1, 0);
        drive(9, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", observed(), '0);
        @(posedge clk);
        #1;
        check("midstream_reset_held", observed(), '0);
        rst_n = 1'b1;
        step_check("after_midstream_reset", 9, 2, 0);

        for (int i = 0; i < 300; i++) begin
            ra   = $urandom_range(0, (1 << LEN) - 1);
            rb   = $urandom_range(0, (1 << LEN) - 1);
`ifdef NBIT_SUB_BORROW_IN_EN
            rbin = $urandom_range(0, 1);
`else
            rbin = 0;
`endif
            apply("random", ra, rb, rbin);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
